// File: rtl/vga_timing_pkg.sv
// Package vga_timing_pkg
// Default 640x480 raster timing and small helpers shared by the raster
// timing generator: line/frame totals and a sync-window compare.
// No ports.
package vga_timing_pkg;

   localparam int DEF_WIDTH  = 640;
   localparam int DEF_HEIGHT = 480;
   localparam int DEF_H_FP   = 16;
   localparam int DEF_H_SYNC = 96;
   localparam int DEF_H_BP   = 48;
   localparam int DEF_V_FP   = 10;
   localparam int DEF_V_SYNC = 2;
   localparam int DEF_V_BP   = 33;

   function automatic int h_total(input int width, input int fp, input int sync, input int bp);
      return width + fp + sync + bp;
   endfunction

   function automatic int v_total(input int height, input int fp, input int sync, input int bp);
      return height + fp + sync + bp;
   endfunction

   // True while lo <= cnt < lo+len; used for both sync pulses.
   function automatic logic in_window(input int cnt, input int lo, input int len);
      return (cnt >= lo) && (cnt < lo + len);
   endfunction

endpackage

// File: rtl/vga_timing_gen_sig_delay.sv
// sig_delay
// W-bit, N-stage shift register advancing on every clk, with a synchronous
// active-low clear that empties every stage. N=0 is a plain wire.
// Ports:
//   clk     in  1   clock
//   resetN  in  1   synchronous active-low clear
//   d       in  W   input bundle
//   q       out W   d delayed N clks
module sig_delay #(
   parameter int N = 1,
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         resetN,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   generate
      if (N == 0) begin : g_pass
         logic unused_pass;
         assign unused_pass = clk ^ resetN;
         assign q = d;
      end else begin : g_sr
         logic [N-1:0][W-1:0] sr;
         always_ff @(posedge clk) begin
            if (!resetN) begin
               sr <= '0;
            end else begin
               sr[0] <= d;
               for (int i = 1; i < N; i++) sr[i] <= sr[i-1];
            end
         end
         assign q = sr[N-1];
      end
   endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Raster timing source: scans an H_TOTAL x V_TOTAL raster and emits pixel
// coordinates, active-video, line/frame start markers and hsync/vsync, plus
// PIPE_DLY-delayed copies of sync/active for the pin side.
// Optional build macro PXL_CLK_DIV2_EN: pixel tick every other clk
// (first tick on the 2nd clk after reset release); otherwise every clk.
// Ports:
//   clk          in   clock
//   resetN       in   synchronous active-low reset
//   pxl_en       out  pixel tick, counters advance on clk edges where it is 1
//   pxl_x/pxl_y  out  column/row, saturating in blanking
//   active       out  inside the WIDTH x HEIGHT window
//   line_start   out  h_cnt==0
//   frame_start  out  h_cnt==0 && v_cnt==0
//   hsync/vsync  out  sync, asserted level SYNC_POL
//   hsync_d/vsync_d/active_d out  same, delayed PIPE_DLY clks
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int HEIGHT   = DEF_HEIGHT,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP,
   parameter int SYNC_POL = 0,
   parameter int PIPE_DLY = 1
) (
   input  logic                      clk,
   input  logic                      resetN,
   output logic                      pxl_en,
   output logic [$clog2(WIDTH)-1:0]  pxl_x,
   output logic [$clog2(HEIGHT)-1:0] pxl_y,
   output logic                      active,
   output logic                      line_start,
   output logic                      frame_start,
   output logic                      hsync,
   output logic                      vsync,
   output logic                      hsync_d,
   output logic                      vsync_d,
   output logic                      active_d
);

   localparam int   HT  = h_total(WIDTH, H_FP, H_SYNC, H_BP);
   localparam int   VT  = v_total(HEIGHT, V_FP, V_SYNC, V_BP);
   localparam int   HW  = $clog2(HT);
   localparam int   VW  = $clog2(VT);
   localparam int   XW  = $clog2(WIDTH);
   localparam int   YW  = $clog2(HEIGHT);
   localparam logic POL = SYNC_POL[0];

   logic [HW-1:0] h_cnt, h_nxt;
   logic [VW-1:0] v_cnt, v_nxt;
   logic          h_wrap;
   // Sync kept active-high internally so the delay-line clear means "deasserted".
   logic          hs_act, vs_act, hs_d_act, vs_d_act;

`ifdef PXL_CLK_DIV2_EN
   logic div_tog;
   always_ff @(posedge clk) begin
      if (!resetN) div_tog <= 1'b0;
      else         div_tog <= ~div_tog;
   end
   assign pxl_en = div_tog;
`else
   assign pxl_en = 1'b1;
`endif

   always_comb begin
      h_wrap = (h_cnt == HW'(HT - 1));
      h_nxt  = h_wrap ? '0 : h_cnt + 1'b1;
      v_nxt  = v_cnt;
      if (h_wrap) v_nxt = (v_cnt == VW'(VT - 1)) ? '0 : v_cnt + 1'b1;
   end

   // Outputs are decoded from the next counter values so that they always
   // describe the (h_cnt, v_cnt) held in the same cycle.
   always_ff @(posedge clk) begin
      if (!resetN) begin
         h_cnt       <= '0;
         v_cnt       <= '0;
         pxl_x       <= '0;
         pxl_y       <= '0;
         active      <= 1'b1;
         line_start  <= 1'b1;
         frame_start <= 1'b1;
         hs_act      <= 1'b0;
         vs_act      <= 1'b0;
      end else if (pxl_en) begin
         h_cnt       <= h_nxt;
         v_cnt       <= v_nxt;
         pxl_x       <= (h_nxt >= HW'(WIDTH))  ? XW'(WIDTH - 1)  : h_nxt[XW-1:0];
         pxl_y       <= (v_nxt >= VW'(HEIGHT)) ? YW'(HEIGHT - 1) : v_nxt[YW-1:0];
         active      <= (h_nxt < HW'(WIDTH)) && (v_nxt < VW'(HEIGHT));
         line_start  <= (h_nxt == '0);
         frame_start <= (h_nxt == '0) && (v_nxt == '0);
         hs_act      <= in_window(int'(h_nxt), WIDTH + H_FP, H_SYNC);
         vs_act      <= in_window(int'(v_nxt), HEIGHT + V_FP, V_SYNC);
      end
   end

   sig_delay #(.N(PIPE_DLY), .W(3)) u_dly (
      .clk    (clk),
      .resetN (resetN),
      .d      ({hs_act, vs_act, active}),
      .q      ({hs_d_act, vs_d_act, active_d})
   );

   assign hsync   = ~(hs_act ^ POL);
   assign vsync   = ~(vs_act ^ POL);
   assign hsync_d = ~(hs_d_act ^ POL);
   assign vsync_d = ~(vs_d_act ^ POL);

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
// Random reset stimulus against a reference model that places the raster
// position as (pixel ticks since reset) mod line/frame totals. Expected
// values are queued per clk and compared by an independent monitor.
// Honours PXL_CLK_DIV2_EN when the design is built with it.
module tb_vga_timing_gen;

   localparam int W = 20, H = 12;
   localparam int HFP = 3, HS = 4, HBP = 5;
   localparam int VFP = 2, VS = 2, VBP = 3;
   localparam int HT = W + HFP + HS + HBP;  // 32
   localparam int VT = H + VFP + VS + VBP;  // 19
`ifdef PXL_CLK_DIV2_EN
   localparam bit DIV = 1'b1;
   localparam int K = 2;
`else
   localparam bit DIV = 1'b0;
   localparam int K = 1;
`endif

   typedef struct {
      logic en;
      int   x, y;
      logic act, ls, fs, hs, vs, hsd, vsd, actd;
      int   dx;
      logic dls, dhs;
   } exp_t;

   typedef struct {
      logic rst, act, hs, vs;
   } hist_t;

   logic clk, resetN;

   logic       a_en, a_act, a_ls, a_fs, a_hs, a_vs, a_hsd, a_vsd, a_actd;
   logic [4:0] a_x;
   logic [3:0] a_y;
   logic       b_en, b_act, b_ls, b_fs, b_hs, b_vs, b_hsd, b_vsd, b_actd;
   logic [4:0] b_x;
   logic [3:0] b_y;
   logic       d_en, d_act, d_ls, d_fs, d_hs, d_vs, d_hsd, d_vsd, d_actd;
   logic [9:0] d_x;
   logic [8:0] d_y;

   vga_timing_gen #(.WIDTH(W), .HEIGHT(H), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
      .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .SYNC_POL(0), .PIPE_DLY(3)) u_a (
      .clk(clk), .resetN(resetN), .pxl_en(a_en), .pxl_x(a_x), .pxl_y(a_y),
      .active(a_act), .line_start(a_ls), .frame_start(a_fs), .hsync(a_hs),
      .vsync(a_vs), .hsync_d(a_hsd), .vsync_d(a_vsd), .active_d(a_actd));

   vga_timing_gen #(.WIDTH(W), .HEIGHT(H), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
      .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .SYNC_POL(1), .PIPE_DLY(0)) u_b (
      .clk(clk), .resetN(resetN), .pxl_en(b_en), .pxl_x(b_x), .pxl_y(b_y),
      .active(b_act), .line_start(b_ls), .frame_start(b_fs), .hsync(b_hs),
      .vsync(b_vs), .hsync_d(b_hsd), .vsync_d(b_vsd), .active_d(b_actd));

   vga_timing_gen u_d (
      .clk(clk), .resetN(resetN), .pxl_en(d_en), .pxl_x(d_x), .pxl_y(d_y),
      .active(d_act), .line_start(d_ls), .frame_start(d_fs), .hsync(d_hs),
      .vsync(d_vs), .hsync_d(d_hsd), .vsync_d(d_vsd), .active_d(d_actd));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   exp_t  sbq[$];
   hist_t hist[$];
   int    ticks, cur_h, cur_v;
   logic  ph;
   int    total, bad;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d t=%0t", name, got, want, $time);
      end
   endtask

   // Reference: position = pixel ticks since reset, folded into the raster.
   task automatic model(input logic r);
      exp_t  e;
      hist_t hh;
      int    h, v, dh;
      logic  ok;
      if (!r) begin
         ticks = 0;
         ph    = 1'b0;
      end else begin
         if (!DIV || ph) ticks++;
         if (DIV) ph = ~ph;
      end
      h = ticks % HT;
      v = (ticks / HT) % VT;
      cur_h = h;
      cur_v = v;
      e.en  = DIV ? ph : 1'b1;
      e.x   = (h < W) ? h : W - 1;
      e.y   = (v < H) ? v : H - 1;
      e.act = (h < W) && (v < H);
      e.ls  = (h == 0);
      e.fs  = (h == 0) && (v == 0);
      e.hs  = (h >= W + HFP) && (h < W + HFP + HS);
      e.vs  = (v >= H + VFP) && (v < H + VFP + VS);
      hh.rst = !r; hh.act = e.act; hh.hs = e.hs; hh.vs = e.vs;
      hist.push_front(hh);
      if (hist.size() > 8) void'(hist.pop_back());
      // Three-clk delay, emptied by any reset edge inside the window.
      ok = (hist.size() > 3);
      for (int i = 0; i < 3 && i < hist.size(); i++) if (hist[i].rst) ok = 1'b0;
      e.hsd  = ok ? hist[3].hs  : 1'b0;
      e.vsd  = ok ? hist[3].vs  : 1'b0;
      e.actd = ok ? hist[3].act : 1'b0;
      dh    = ticks % 800;
      e.dx  = (dh < 640) ? dh : 639;
      e.dls = (dh == 0);
      e.dhs = (dh >= 656) && (dh < 752);
      sbq.push_back(e);
   endtask

   task automatic step(input logic r);
      @(negedge clk);
      resetN = r;
      @(posedge clk);
      model(r);
   endtask

   // Monitor: one expected record per clk, compared mid-cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("pxl_en",      a_en,   e.en);
            chk("pxl_x",       a_x,    e.x);
            chk("pxl_y",       a_y,    e.y);
            chk("active",      a_act,  e.act);
            chk("line_start",  a_ls,   e.ls);
            chk("frame_start", a_fs,   e.fs);
            chk("hsync",       a_hs,   !e.hs);
            chk("vsync",       a_vs,   !e.vs);
            chk("hsync_d3",    a_hsd,  !e.hsd);
            chk("vsync_d3",    a_vsd,  !e.vsd);
            chk("active_d3",   a_actd, e.actd);
            chk("hsync_pos",   b_hs,   e.hs);
            chk("vsync_pos",   b_vs,   e.vs);
            chk("hsync_d0",    b_hsd,  e.hs);
            chk("vsync_d0",    b_vsd,  e.vs);
            chk("active_d0",   b_actd, e.act);
            chk("def_pxl_x",   d_x,    e.dx);
            chk("def_line_st", d_ls,   e.dls);
            chk("def_hsync",   d_hs,   !e.dhs);
         end
      end
   end

   initial begin
      int n;
      total = 0; bad = 0; ticks = 0; ph = 1'b0; cur_h = 0; cur_v = 0;
      resetN = 1'b0;
      repeat (5) step(1'b0);
      // Two clean frames (also covers one full line of the default raster).
      repeat (2 * HT * VT * K) step(1'b1);
      // Reset pulse landing inside hsync, mid-frame.
      n = 0;
      while (!(cur_h == W + HFP + 1 && cur_v == 5) && n < HT * VT * K) begin
         step(1'b1);
         n++;
      end
      chk("reach_mid_sync", (n < HT * VT * K), 1);
      step(1'b0);
      repeat (50) step(1'b1);
      // Sparse random resets.
      repeat (6000) step($urandom_range(0, 399) != 0);
      @(negedge clk); #1;
      @(negedge clk); #1;
      chk("sb_drain", sbq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
